// File: rtl/hydra_rd_sink.sv
// Consumer for one hydra read port: requests packets, captures header and body,
// checks body length, buffers words in a show-ahead FIFO and replays them downstream.
module hydra_rd_sink #(
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 512,
  parameter int MAX_PKT_WORDS = 256,
  parameter int RESP_TIMEOUT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  ready,
  input  logic                  rd_sop,
  input  logic                  rd_eop,
  input  logic                  rd_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           err_cnt,
  output logic [15:0]           timeout_cnt,
  output logic                  busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 3;
  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [AW+1:0] ROOM_LIMIT = (AW+2)'(FIFO_DEPTH - MAX_PKT_WORDS);
  localparam logic [8:0]    CNT_SAT    = 9'd256;

  typedef enum logic [2:0] {IDLE, REQ, WAIT_SOP, HDR, BODY} state_t;
  state_t state, state_nxt;

  logic [TW-1:0]         wait_cnt;
  logic [7:0]            len_q;
  logic [8:0]            body_cnt, cnt_nxt;
  logic                  hold_vld_p0, hold_close_p0, hold_err_p0, hold_sop_p0;
  logic [DATA_WIDTH-1:0] hold_data_p0;
  logic                  drop_q;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;

  logic in_pkt, accept, close_eop, close_sop, hdr_abort, hdr_resop, close_err;
  logic wr_req, wr_en, rd_en, full, room, tmo;
  logic [7:0] len_cur;
  logic [EW-1:0] head;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    in_pkt    = (state == HDR) || (state == BODY);
    accept    = in_pkt && rd_vld && !rd_sop;
    close_eop = in_pkt && !rd_sop && rd_eop && ((state == BODY) || rd_vld);
    hdr_abort = (state == HDR) && !rd_sop && rd_eop && !rd_vld;
    close_sop = (state == BODY) && rd_sop;
    hdr_resop = (state == HDR) && rd_sop;
    len_cur   = (state == HDR) ? rd_data[11:4] : len_q;
    if (state == HDR)
      cnt_nxt = 9'd0;
    else if (accept && body_cnt != CNT_SAT)
      cnt_nxt = body_cnt + 9'd1;
    else
      cnt_nxt = body_cnt;
    close_err = close_sop || drop_q || (cnt_nxt != {1'b0, len_cur});
    full      = (count == (AW+1)'(FIFO_DEPTH));
    wr_req    = hold_vld_p0 && (accept || hold_close_p0);
    wr_en     = wr_req && !full;
    rd_en     = out_vld && out_rdy;
    // The holding register counts against free space so a full packet always fits.
    room      = ({1'b0, count} + (AW+2)'(hold_vld_p0)) <= ROOM_LIMIT;
    tmo       = (state == WAIT_SOP) && !rd_sop && (wait_cnt == TW'(RESP_TIMEOUT - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (en && room) state_nxt = REQ;
      REQ:      state_nxt = WAIT_SOP;
      WAIT_SOP: if (rd_sop) state_nxt = HDR;
                else if (tmo) state_nxt = IDLE;
      HDR:      if (rd_sop) state_nxt = HDR;
                else if (close_eop || hdr_abort) state_nxt = IDLE;
                else if (accept) state_nxt = BODY;
      BODY:     if (rd_sop) state_nxt = HDR;
                else if (close_eop) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      hold_vld_p0   <= 1'b0;
      hold_close_p0 <= 1'b0;
      hold_err_p0   <= 1'b0;
      drop_q        <= 1'b0;
      pkt_cnt       <= '0;
      err_cnt       <= '0;
      timeout_cnt   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT_SOP) ? wait_cnt + TW'(1) : '0;
      // Stage p0: a closing word waits here one cycle, then flushes with eop set.
      if (accept) begin
        hold_vld_p0   <= 1'b1;
        hold_close_p0 <= close_eop;
        hold_err_p0   <= close_err;
      end else if (close_eop || close_sop) begin
        hold_close_p0 <= 1'b1;
        hold_err_p0   <= close_err;
      end else if (wr_req) begin
        hold_vld_p0   <= 1'b0;
        hold_close_p0 <= 1'b0;
      end
      if (wr_req && full)
        drop_q <= 1'b1;
      else if (accept && state == HDR)
        drop_q <= 1'b0;
      if (close_eop && !close_err)
        pkt_cnt <= sat_inc(pkt_cnt);
      if ((close_eop && close_err) || close_sop || hdr_abort || hdr_resop)
        err_cnt <= sat_inc(err_cnt);
      if (tmo)
        timeout_cnt <= sat_inc(timeout_cnt);
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data_p0 <= rd_data;
      hold_sop_p0  <= (state == HDR);
    end
    if (accept && state == HDR) len_q <= rd_data[11:4];
    if (accept) body_cnt <= cnt_nxt;
    // Stage p1: FIFO entry {err, sop, eop, data}.
    if (wr_en)
      mem[wr_ptr] <= {hold_close_p0 & (hold_err_p0 | drop_q), hold_sop_p0, hold_close_p0, hold_data_p0};
  end

  assign head     = mem[rd_ptr];
  assign out_vld  = (count != '0);
  assign out_err  = out_vld & head[EW-1];
  assign out_sop  = out_vld & head[EW-2];
  assign out_eop  = out_vld & head[EW-3];
  assign out_data = out_vld ? head[DATA_WIDTH-1:0] : '0;
  assign ready    = (state == REQ);
  assign busy     = (state != IDLE);
endmodule

// File: tb/tb_hydra_rd_sink.sv
// Directed bench for hydra_rd_sink: drives hydra read-port packets and checks the replayed stream and counters.
module tb_hydra_rd_sink;
  logic        clk = 1'b0;
  logic        rst, en, ready, rd_sop, rd_eop, rd_vld;
  logic [15:0] rd_data;
  logic        out_vld, out_rdy, out_sop, out_eop, out_err, busy;
  logic [15:0] out_data, pkt_cnt, err_cnt, timeout_cnt;

  int tests = 0;
  int fails = 0;
  logic [18:0] cap[$];
  logic [18:0] expq[$];

  always #5 clk = ~clk;

  hydra_rd_sink dut (
    .clk(clk), .rst(rst), .en(en), .ready(ready),
    .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_sop(out_sop), .out_eop(out_eop),
    .out_err(out_err), .out_data(out_data),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .timeout_cnt(timeout_cnt), .busy(busy)
  );

  // Transfers are taken at the next rising edge; inputs are stable by the falling edge.
  always @(negedge clk)
    if (!rst && out_vld && out_rdy) cap.push_back({out_err, out_sop, out_eop, out_data});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int max);
    bit seen = 1'b0;
    en = 1'b1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (ready) begin seen = 1'b1; break; end
    end
    en = 1'b0;
    chk(tag, 32'(seen), 32'd1);
  endtask

  // Called right after ready was observed; rd_sop follows one cycle later.
  task automatic send_pkt(input logic [15:0] hdr, input int nbody, input logic [15:0] base,
                          input bit gaps, input bit coinc);
    tick();
    rd_sop = 1'b1;
    tick();
    rd_sop = 1'b0;
    rd_vld = 1'b1;
    rd_data = hdr;
    tick();
    for (int i = 0; i < nbody; i++) begin
      rd_vld  = 1'b1;
      rd_data = base + 16'(i);
      rd_eop  = coinc && (i == nbody - 1);
      tick();
      rd_vld = 1'b0;
      rd_eop = 1'b0;
      if (gaps && i != nbody - 1) begin tick(); tick(); end
    end
    if (!coinc) begin
      rd_eop = 1'b1;
      tick();
      rd_eop = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [15:0] hdr, input int nbody, input logic [15:0] base, input bit err);
    expq.push_back({1'b0, 1'b1, 1'b0, hdr});
    for (int i = 0; i < nbody; i++)
      expq.push_back({err && (i == nbody - 1), 1'b0, i == nbody - 1, base + 16'(i)});
  endtask

  task automatic drain_check(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (cap.size() >= expq.size() && !out_vld) break;
      tick();
    end
    chk({tag, " words"}, 32'(cap.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < cap.size(); i++) begin
      chk($sformatf("%s word%0d", tag, i), 32'(cap[i]), 32'(expq[i]));
      if (cap[i] !== expq[i]) break;
    end
    cap.delete();
    expq.delete();
  endtask

  initial begin
    bit seen;
    rst = 1'b1; en = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_vld = 1'b0;
    rd_data = '0; out_rdy = 1'b1;
    tick(); tick();
    chk("reset outputs", {8'd0, out_vld, out_sop, out_eop, out_err, ready, busy, out_data}, 32'd0);
    chk("reset counters", {pkt_cnt, err_cnt | timeout_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // T1: clean packet, len 31
    wait_ready("t1 ready", 10);
    push_exp(16'h01F6, 31, 16'hA000, 1'b0);
    send_pkt(16'h01F6, 31, 16'hA000, 1'b0, 1'b0);
    drain_check("t1", 100);
    chk("t1 pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("t1 err_cnt", 32'(err_cnt), 32'd0);

    // T2: short body, len 40 with 38 body words
    wait_ready("t2 ready", 10);
    push_exp(16'h0281, 38, 16'hB000, 1'b1);
    send_pkt(16'h0281, 38, 16'hB000, 1'b0, 1'b0);
    drain_check("t2", 100);
    chk("t2 err_cnt", 32'(err_cnt), 32'd1);
    chk("t2 pkt_cnt", 32'(pkt_cnt), 32'd1);

    // T3: request without response times out
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = ready; end
    chk("t3 ready", 32'(seen), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t3 wait%0d busy/ready", i), {30'd0, busy, ready}, 32'd2);
    end
    tick();
    chk("t3 idle busy/ready", {30'd0, busy, ready}, 32'd0);
    chk("t3 timeout_cnt", 32'(timeout_cnt), 32'd1);
    tick();
    chk("t3 re-request", 32'(ready), 32'd1);
    en = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t3 timeout_cnt 2", 32'(timeout_cnt), 32'd2);

    // T5: gapped body with eop on the last valid word, len 100
    wait_ready("t5 ready", 10);
    push_exp(16'h0643, 100, 16'hC000, 1'b0);
    send_pkt(16'h0643, 100, 16'hC000, 1'b1, 1'b1);
    drain_check("t5", 100);
    chk("t5 pkt_cnt", 32'(pkt_cnt), 32'd2);

    // T4: backpressure with three maximum packets
    out_rdy = 1'b0;
    wait_ready("t4 ready a", 10);
    push_exp(16'h0FF0, 255, 16'h1000, 1'b0);
    send_pkt(16'h0FF0, 255, 16'h1000, 1'b0, 1'b0);
    wait_ready("t4 ready b", 10);
    push_exp(16'h0FF5, 255, 16'h2000, 1'b0);
    send_pkt(16'h0FF5, 255, 16'h2000, 1'b0, 1'b0);
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (ready) seen = 1'b1; end
    en = 1'b0;
    chk("t4 ready withheld", 32'(seen), 32'd0);
    chk("t4 stable head", {13'd0, out_vld, out_sop, out_eop, out_data}, {13'd0, 3'b110, 16'h0FF0});
    out_rdy = 1'b1;
    wait_ready("t4 ready c", 600);
    push_exp(16'h0FFA, 255, 16'h3000, 1'b0);
    send_pkt(16'h0FFA, 255, 16'h3000, 1'b0, 1'b0);
    drain_check("t4", 2000);
    chk("t4 pkt_cnt", 32'(pkt_cnt), 32'd5);

    // T6: reset in the middle of a body
    wait_ready("t6 ready", 10);
    tick();
    rd_sop = 1'b1;
    tick();
    rd_sop = 1'b0;
    rd_vld = 1'b1;
    rd_data = 16'h01F6;
    for (int i = 0; i < 10; i++) begin tick(); rd_data = 16'hD000 + 16'(i); end
    rst = 1'b1;
    rd_vld = 1'b0;
    #1;
    chk("t6 reset outputs", {8'd0, out_vld, out_sop, out_eop, out_err, ready, busy, out_data}, 32'd0);
    chk("t6 reset counters", {pkt_cnt, err_cnt | timeout_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    cap.delete();
    tick();
    chk("t6 fifo empty", 32'(out_vld), 32'd0);
    wait_ready("t6 ready after", 10);
    push_exp(16'h01F6, 31, 16'hE000, 1'b0);
    send_pkt(16'h01F6, 31, 16'hE000, 1'b0, 1'b0);
    drain_check("t6", 100);
    chk("t6 pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("t6 err/timeout", {err_cnt, timeout_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
